// File: rtl/data_ram_resp.sv
// Word-addressed data RAM with 1-cycle read response, 1-entry write buffer and sticky misalignment capture.
// Define MEM_ACCESS_CNT_EN to add the rd_cnt/wr_cnt accepted-access counters.
module data_ram_resp #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_din,
    output logic [31:0] mem_dout,
    output logic        rd_valid,
    output logic        misalign_err,
    output logic [31:0] err_addr
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    logic                  aligned;
    logic                  any_req;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [ADDR_WIDTH-1:0] idx;

    logic                  wbuf_valid_q, wbuf_valid_d;
    logic [ADDR_WIDTH-1:0] wbuf_idx_q,   wbuf_idx_d;
    logic [31:0]           wbuf_data_q,  wbuf_data_d;

    logic                  rd_valid_q,     rd_valid_d;
    logic                  fwd_hit_q,      fwd_hit_d;
    logic [31:0]           fwd_data_q,     fwd_data_d;
    logic                  dout_clr_q,     dout_clr_d;
    logic                  misalign_err_q, misalign_err_d;
    logic [31:0]           err_addr_q,     err_addr_d;
    logic [31:0]           ram_rd_q;

    always_comb begin
        aligned = (mem_addr[1:0] == 2'b00);
        idx     = mem_addr[ADDR_WIDTH+1:2];
        any_req = mem_ren | mem_wen;
        rd_acc  = !rst && mem_ren && aligned;
        wr_acc  = !rst && mem_wen && aligned;
    end

    always_comb begin
        // The buffer drains every cycle; it only stays valid if a new write refills it.
        wbuf_valid_d   = wr_acc;
        wbuf_idx_d     = wr_acc ? idx : wbuf_idx_q;
        wbuf_data_d    = wr_acc ? mem_din : wbuf_data_q;

        rd_valid_d     = rd_acc;
        fwd_hit_d      = fwd_hit_q;
        fwd_data_d     = fwd_data_q;
        dout_clr_d     = dout_clr_q;
        if (rd_acc) begin
            fwd_hit_d  = wbuf_valid_q && (wbuf_idx_q == idx);
            fwd_data_d = wbuf_data_q;
            dout_clr_d = 1'b0;
        end

        misalign_err_d = misalign_err_q;
        err_addr_d     = err_addr_q;
        if (!rst && any_req && !aligned && !misalign_err_q) begin
            misalign_err_d = 1'b1;
            err_addr_d     = mem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbuf_valid_q   <= 1'b0;
            wbuf_idx_q     <= '0;
            wbuf_data_q    <= '0;
            rd_valid_q     <= 1'b0;
            fwd_hit_q      <= 1'b0;
            fwd_data_q     <= '0;
            dout_clr_q     <= 1'b1;
            misalign_err_q <= 1'b0;
            err_addr_q     <= '0;
        end else begin
            wbuf_valid_q   <= wbuf_valid_d;
            wbuf_idx_q     <= wbuf_idx_d;
            wbuf_data_q    <= wbuf_data_d;
            rd_valid_q     <= rd_valid_d;
            fwd_hit_q      <= fwd_hit_d;
            fwd_data_q     <= fwd_data_d;
            dout_clr_q     <= dout_clr_d;
            misalign_err_q <= misalign_err_d;
            err_addr_q     <= err_addr_d;
        end
    end

    // Array port: commit of the buffered write plus a registered read; a pending write reset away never lands.
    always_ff @(posedge clk) begin
        if (!rst && wbuf_valid_q) begin
            mem[wbuf_idx_q] <= wbuf_data_q;
        end
        if (rd_acc) begin
            ram_rd_q <= mem[idx];
        end
    end

    assign mem_dout     = dout_clr_q ? 32'h0 : (fwd_hit_q ? fwd_data_q : ram_rd_q);
    assign rd_valid     = rd_valid_q;
    assign misalign_err = misalign_err_q;
    assign err_addr     = err_addr_q;

`ifdef MEM_ACCESS_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_acc ? rd_cnt_q + 32'd1 : rd_cnt_q;
        wr_cnt_d = wr_acc ? wr_cnt_q + 32'd1 : wr_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_ram_resp.sv
// Scoreboard bench for data_ram_resp: a word-level memory model predicts every read and status output.
module tb_data_ram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_din;
    logic [31:0] mem_dout;
    logic        rd_valid, misalign_err;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    data_ram_resp #(.ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .rd_valid     (rd_valid),
        .misalign_err (misalign_err),
        .err_addr     (err_addr)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_item_t;

    rd_item_t    rdq[$];
    logic [31:0] ref_mem [256];
    int          vectors    = 0;
    int          miscompares = 0;
    int          edge_cnt   = 0;

    logic [31:0] exp_dout;
    logic        exp_err;
    logic [31:0] exp_err_addr;

    // Most recent accepted write, remembered so a reset in the very next cycle can undo it.
    bit          pw_valid;
    int          pw_idx;
    logic [31:0] pw_old;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h (edge %0d)", name, act, exp, edge_cnt);
        end
    endfunction

    task automatic step(input bit r, input bit ren, input bit wen,
                        input logic [31:0] a, input logic [31:0] d);
        int i;
        bit al;
        @(negedge clk);
        rst      = r;
        mem_ren  = ren;
        mem_wen  = wen;
        mem_addr = a;
        mem_din  = d;
        i  = int'(a[9:2]);
        al = (a[1:0] == 2'b00);
        if (r) begin
            if (pw_valid) ref_mem[pw_idx] = pw_old;
            pw_valid     = 0;
            exp_dout     = 32'h0;
            exp_err      = 1'b0;
            exp_err_addr = 32'h0;
        end else begin
            if ((ren || wen) && !al && !exp_err) begin
                exp_err      = 1'b1;
                exp_err_addr = a;
            end
            if (al && ren) begin
                rdq.push_back('{data: ref_mem[i], due: edge_cnt + 1});
                exp_dout = ref_mem[i];
            end
            pw_valid = 0;
            if (al && wen) begin
                pw_valid   = 1;
                pw_idx     = i;
                pw_old     = ref_mem[i];
                ref_mem[i] = d;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 32'h0);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        rd_item_t it;
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            if (rd_valid === 1'b1) begin
                if (rdq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_rd_valid: got rd_valid=1 expected 0 (edge %0d)", edge_cnt);
                end else begin
                    it = rdq.pop_front();
                    check("rd_latency", 32'(edge_cnt), 32'(it.due));
                    check("rd_data", mem_dout, it.data);
                end
            end else if (rdq.size() > 0 && rdq[0].due <= edge_cnt) begin
                it = rdq.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing_rd_valid: got rd_valid=%b expected 1 for data %08h (edge %0d)",
                         rd_valid, it.data, edge_cnt);
            end
            check("mem_dout_hold", mem_dout, exp_dout);
            check("misalign_err", {31'h0, misalign_err}, {31'h0, exp_err});
            check("err_addr", err_addr, exp_err_addr);
        end
    end

    initial begin
        logic [31:0] a;
        int          idx;
        rst          = 1'b1;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;
        mem_addr     = 32'h0;
        mem_din      = 32'h0;
        exp_dout     = 32'h0;
        exp_err      = 1'b0;
        exp_err_addr = 32'h0;
        pw_valid     = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

        step(1, 0, 0, 32'h0, 32'h0);
        step(1, 1, 1, 32'h4, 32'hDEAD);
        for (int i = 0; i < 256; i++) step(0, 0, 1, 32'(i) << 2, $urandom);
        idle();

        // Write then immediate read of the same word (forwarded from the buffer).
        step(0, 0, 1, 32'h10, 32'h1234_5678);
        step(0, 1, 0, 32'h10, 32'h0);
        idle();
        // Back-to-back writes followed by reads.
        step(0, 0, 1, 32'h0, 32'hA);
        step(0, 0, 1, 32'h4, 32'hB);
        step(0, 1, 0, 32'h0, 32'h0);
        step(0, 1, 0, 32'h4, 32'h0);
        idle();
        // Read-before-write on simultaneous ren+wen.
        step(0, 0, 1, 32'h8, 32'h55);
        step(0, 1, 1, 32'h8, 32'h66);
        step(0, 1, 0, 32'h8, 32'h0);
        idle();
        // Misaligned accesses: first address sticks, nothing changes.
        step(0, 0, 1, 32'h3, 32'hFFFF_FFFF);
        step(0, 1, 0, 32'h7, 32'h0);
        step(0, 1, 0, 32'h0, 32'h0);
        idle();
        // Reset right after a write discards the buffered entry.
        step(0, 0, 1, 32'h20, 32'h77);
        step(1, 1, 1, 32'h20, 32'h99);
        step(0, 1, 0, 32'h20, 32'h0);
        idle();
        // Aliased address (upper bits set) hits the same word.
        step(0, 0, 1, 32'hFFFF_FC40, 32'hCAFE_F00D);
        idle();
        step(0, 1, 0, 32'h0000_0040, 32'h0);
        idle();

        for (int n = 0; n < 3000; n++) begin
            idx = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255));
            a   = ($urandom & 32'hFFFF_FC00) | (32'(idx) << 2);
            if ($urandom_range(0, 15) == 0) a[1:0] = 2'($urandom_range(1, 3));
            step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 a, $urandom);
        end

        idle();
        idle();
        idle();
        check("rd_queue_drained", 32'(rdq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
